mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single shared memory port (cache/ram, 16-bit word address, 32-bit data) between the instruction-fetch port and the load/store data port.
- Sequences each access over a fixed multi-cycle latency and returns read data with a one-cycle ack pulse.
- Sits between the CPU pipeline and the cache; the pipeline stalls on an outstanding req without ack.

Parameters:
- AW, 16, word address width.
- DW, 32, data width.
- LAT, 2, cycles the memory address is held per access; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- i_req  input  1  instruction read request; held until i_ack.
- i_addr  input  AW  instruction word address.
- i_rdata  output  DW  instruction read data; registered.
- i_ack  output  1  one-cycle completion pulse, instruction port.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  data request is a write.
- d_addr  input  AW  data word address.
- d_wdata  input  DW  data write value.
- d_rdata  output  DW  data read data; registered.
- d_ack  output  1  one-cycle completion pulse, data port.
- m_addr  output  AW  address to cache/ram; registered.
- m_we  output  1  write strobe to cache/ram.
- m_wdata  output  DW  write data to cache/ram; registered.
- m_rdata  input  DW  combinational read data from cache/ram.
- busy  output  1  high in ACCESS and DONE.

Behaviour:
- Reset values:
  - state = IDLE.
  - i_ack = d_ack = m_we = busy = 0.
  - i_rdata = d_rdata = m_addr = m_wdata = 0.
  - cnt = 0.
  - last grant = instruction port.
  - Reset wins over any other event. Reset mid-access aborts it: no ack, no m_we, no rdata update.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Sample i_req and d_req.
  - If either is high, grant one requester and latch its addr into m_addr, plus d_wdata into m_wdata for a data write.
  - Latch grant id and we flag, load cnt = LAT-1, go to ACCESS.
  - If neither is high, stay in IDLE; outputs hold.
- Priority (default build): data port beats instruction port when both request in the same IDLE cycle.
- ACCESS:
  - m_addr held stable.
  - If cnt != 0: decrement cnt.
  - If cnt == 0:
    - For a read, capture m_rdata into the granted port's rdata.
    - Go to DONE.
  - m_we = 1 only in the final ACCESS cycle (cnt == 0) of a write, so exactly one write edge per store. m_we is never high for reads or in any other state.
- DONE:
  - Granted port's ack = 1 for exactly this cycle. The other ack stays 0.
  - i_req and d_req are ignored in DONE.
  - Next state is always IDLE.
- Timing: if req is high in IDLE before edge N, then:
  - ACCESS occupies cycles N+1..N+LAT.
  - ack is high in cycle N+LAT+1.
  - Next earliest grant edge is N+LAT+2.
- rdata is valid from the ack cycle and held until the next read completion on that port. A write completion leaves d_rdata unchanged.
- Requester rule: deassert req, or present a new request, by the edge ending the ack cycle. Dropping req mid-access does not cancel the access; it still completes and acks.
- i_addr, d_addr and d_wdata changes after grant have no effect on the access in flight.
- LAT = 1: a single ACCESS cycle with cnt already 0.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Round-robin priority on simultaneous requests: the port not granted last wins.
  - Last grant is updated on every grant, including uncontended ones.
  - Guarantees neither port waits more than one foreign access.
- Undefined: fixed data-over-instruction priority; last-grant register not implemented.

Test Plan:
- Instruction read, LAT=2: ram word 0x0010 = 0xDEADBEEF; i_req=1, i_addr=0x0010 at edge N -> m_addr=0x0010 for cycles N+1..N+2; i_ack=1 only at N+3; i_rdata=0xDEADBEEF; m_we never 1.
- Data write then read: d_req=1, d_we=1, d_addr=0x0040, d_wdata=0x12345678 -> m_we=1 for exactly one cycle (N+2); d_ack at N+3. A following read of 0x0040 returns d_rdata=0x12345678.
- Contention, default build: i_req and d_req both high at same IDLE edge -> data served first (d_ack at N+3), instruction granted at N+4, i_ack at N+7.
- Contention, MEM_ARB_RR_EN defined: both held continuously for 4 accesses -> ack order d, i, d, i when last grant is data-reset-adjusted; with reset last grant = instruction, first grant = data, then i, d, i.
- Reset mid-access: d_req write to 0x0020 value 0xAAAA5555; reset=1 in first ACCESS cycle -> state IDLE next cycle, no d_ack, m_we never asserted, ram 0x0020 unchanged, all outputs 0.
- Request drop: i_req pulsed one cycle only -> access still runs; i_ack pulses once at N+3; no second access starts.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one cache/ram port between instruction fetch and
// load/store. Each access holds m_addr for LAT cycles (ACCESS). Read data is
// captured at the end of the last ACCESS cycle. The granted port then receives
// a one-cycle ack (DONE).
//
// Ports:
//   clk, reset              - clock; synchronous active-high reset
//   i_req/i_addr            - instruction read request (held until i_ack)
//   i_rdata/i_ack           - registered instruction data, completion pulse
//   d_req/d_we/d_addr/d_wdata - data request (held until d_ack)
//   d_rdata/d_ack           - registered load data, completion pulse
//   m_addr/m_we/m_wdata     - registered address/data and write strobe to memory
//   m_rdata                 - combinational read data from memory
//   busy                    - high in ACCESS and DONE
//
// Build option: define MEM_ARB_RR_EN for round-robin priority on simultaneous
// requests. Otherwise the data port always wins.
module mem_arbiter #(
  parameter int unsigned AW  = 16,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gnt_d_q, gnt_d_d;   // 1: data port owns the access in flight
  logic          we_q, we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          pick_d;

`ifdef MEM_ARB_RR_EN
  logic last_d_q, last_d_d;          // 1: most recent grant went to data port

  // Under contention the port that was not granted last wins.
  always_comb pick_d = d_req && (!i_req || !last_d_q);
`else
  always_comb pick_d = d_req;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d_d   = gnt_d_q;
    we_d      = we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d_d  = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d_d  = pick_d;
          we_d     = pick_d && d_we;
          m_addr_d = pick_d ? d_addr : i_addr;
          if (pick_d && d_we) m_wdata_d = d_wdata;
          cnt_d    = CNT_INIT;
          state_d  = ACCESS;
`ifdef MEM_ARB_RR_EN
          last_d_d = pick_d;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (gnt_d_q) d_rdata_d = m_rdata;
            else         i_rdata_d = m_rdata;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_d_q   <= gnt_d_d;
      we_q      <= we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  // Strobe only in the last ACCESS cycle, so each store produces exactly one write edge.
  assign m_we    = (state_q == ACCESS) && (cnt_q == '0) && we_q;
  assign i_ack   = (state_q == DONE) && !gnt_d_q;
  assign d_ack   = (state_q == DONE) &&  gnt_d_q;
  assign busy    = (state_q != IDLE);
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. u_dut uses LAT=2 on a small modelled RAM.
// u_dut_lat1 uses LAT=1 on a pattern-generating memory.
module tb_mem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          i_req, d_req, d_we, i_ack, d_ack, m_we, busy;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] d_wdata, i_rdata, d_rdata, m_wdata, m_rdata;

  logic          i_req1, d_req1, d_we1, i_ack1, d_ack1, m_we1, busy1;
  logic [AW-1:0] i_addr1, d_addr1, m_addr1;
  logic [DW-1:0] d_wdata1, i_rdata1, d_rdata1, m_wdata1, m_rdata1;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_ack(i_ack1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ack(d_ack1),
    .m_addr(m_addr1), .m_we(m_we1), .m_wdata(m_wdata1), .m_rdata(m_rdata1),
    .busy(busy1)
  );

  // RAM model: words never written return a fixed preload pattern
  logic [31:0] ram [256];
  bit          wr_v [256];

  function automatic logic [31:0] mem_default(input logic [7:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h20:   return 32'h01020304;
      default: return {24'h5A5A5A, a};
    endcase
  endfunction

  function automatic logic [31:0] mem_read(input logic [7:0] a);
    return wr_v[a] ? ram[a] : mem_default(a);
  endfunction

  assign m_rdata  = mem_read(m_addr[7:0]);
  assign m_rdata1 = {16'hC0DE, m_addr1};

  int we_cnt = 0, we1_cnt = 0, i_ack_cnt = 0, d_ack_cnt = 0;
  always @(posedge clk) begin
    if (m_we) begin
      ram[m_addr[7:0]]  <= m_wdata;
      wr_v[m_addr[7:0]] <= 1'b1;
      we_cnt <= we_cnt + 1;
    end
    if (m_we1) we1_cnt   <= we1_cnt + 1;
    if (i_ack) i_ack_cnt <= i_ack_cnt + 1;
    if (d_ack) d_ack_cnt <= d_ack_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d_cyc, i_cyc, nacks, need, we0, dack0, ia0, first;
  logic [3:0] order;

  initial begin
    reset = 1'b1;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req1 = 0; i_addr1 = '0; d_req1 = 0; d_we1 = 0; d_addr1 = '0; d_wdata1 = '0;
    step(); step();
    check("rst_ctrl", {28'd0, i_ack, d_ack, m_we, busy}, 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_m_addr", {16'd0, m_addr}, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    reset = 1'b0;
    step();

    // Instruction read; the address changes after grant and must not matter
    i_req = 1; i_addr = 16'h0010;
    step();
    check("ird_c1_addr", {16'd0, m_addr}, 32'h10);
    check("ird_c1_busy", {31'd0, busy}, 32'h1);
    check("ird_c1_ack", {31'd0, i_ack}, 32'h0);
    i_addr = 16'h0099;
    step();
    check("ird_c2_addr", {16'd0, m_addr}, 32'h10);
    check("ird_c2_ack", {31'd0, i_ack}, 32'h0);
    step();
    check("ird_c3_acks", {30'd0, i_ack, d_ack}, 32'h2);
    check("ird_rdata", i_rdata, 32'hDEADBEEF);
    i_req = 0;
    step();
    check("ird_c4_idle", {30'd0, i_ack, busy}, 32'h0);
    check("ird_no_we", we_cnt, 32'd0);

    // Data write; address and data change after grant and must not matter
    d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 32'h12345678;
    step();
    check("wr_c1_we", {31'd0, m_we}, 32'h0);
    check("wr_c1_addr", {16'd0, m_addr}, 32'h40);
    check("wr_c1_wdata", m_wdata, 32'h12345678);
    d_addr = 16'h0041; d_wdata = 32'hFFFFFFFF;
    step();
    check("wr_c2_we", {31'd0, m_we}, 32'h1);
    check("wr_c2_wdata", m_wdata, 32'h12345678);
    step();
    check("wr_c3_acks", {29'd0, m_we, i_ack, d_ack}, 32'h1);
    check("wr_d_rdata_kept", d_rdata, 32'h0);
    d_req = 0; d_we = 0; d_addr = 16'h0040;
    step();
    check("wr_we_count", we_cnt, 32'd1);
    check("wr_ram", mem_read(8'h40), 32'h12345678);

    // Read back the stored word
    d_req = 1;
    step(); step(); step();
    check("rd_ack", {31'd0, d_ack}, 32'h1);
    check("rd_d_rdata", d_rdata, 32'h12345678);
    check("rd_i_rdata_kept", i_rdata, 32'hDEADBEEF);
    d_req = 0;
    step();

    // Contention from a freshly reset arbiter
    reset = 1; step(); reset = 0; step();
    i_addr = 16'h0010; d_addr = 16'h0040; d_we = 0;
    i_req = 1; d_req = 1;
    d_cyc = -1; i_cyc = -1; nacks = 0; order = '0;
`ifdef MEM_ARB_RR_EN
    need = 4;
`else
    need = 2;
`endif
    for (int c = 1; c <= 40 && nacks < need; c++) begin
      step();
      if (d_ack || i_ack) begin
        nacks++;
        order = {order[2:0], d_ack};
        if (d_ack) d_cyc = c;
        if (i_ack) i_cyc = c;
`ifndef MEM_ARB_RR_EN
        if (d_ack) d_req = 0;
        if (i_ack) i_req = 0;
`endif
      end
    end
    i_req = 0; d_req = 0;
    check("arb_ack_count", nacks, need);
`ifdef MEM_ARB_RR_EN
    check("rr_order", {28'd0, order}, 32'hA);
    check("rr_last_d_cyc", d_cyc, 32'd11);
    check("rr_last_i_cyc", i_cyc, 32'd15);
`else
    check("fix_d_ack_cyc", d_cyc, 32'd3);
    check("fix_i_ack_cyc", i_cyc, 32'd7);
`endif
    check("arb_d_rdata", d_rdata, 32'h12345678);
    check("arb_i_rdata", i_rdata, 32'hDEADBEEF);
    step();

    // Reset during the first ACCESS cycle of a write
    d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 32'hAAAA5555;
    we0 = we_cnt; dack0 = d_ack_cnt;
    step();
    check("rst_mid_busy", {31'd0, busy}, 32'h1);
    reset = 1;
    step();
    check("rst_mid_ctrl", {28'd0, i_ack, d_ack, m_we, busy}, 32'h0);
    check("rst_mid_m_addr", {16'd0, m_addr}, 32'h0);
    check("rst_mid_m_wdata", m_wdata, 32'h0);
    check("rst_mid_rdata", i_rdata | d_rdata, 32'h0);
    reset = 0; d_req = 0; d_we = 0;
    step(); step(); step(); step();
    check("rst_mid_no_ack", d_ack_cnt - dack0, 32'd0);
    check("rst_mid_no_we", we_cnt - we0, 32'd0);
    check("rst_mid_ram", mem_read(8'h20), 32'h01020304);

    // Single-cycle request pulse still completes, exactly once
    i_addr = 16'h0030; i_req = 1; ia0 = i_ack_cnt; first = -1;
    step();
    i_req = 0;
    for (int c = 2; c <= 8; c++) begin
      step();
      if (i_ack && first < 0) first = c;
    end
    check("drop_ack_cyc", first, 32'd3);
    check("drop_ack_count", i_ack_cnt - ia0, 32'd1);
    check("drop_idle", {31'd0, busy}, 32'h0);
    check("drop_rdata", i_rdata, 32'h5A5A5A30);

    // LAT=1: single ACCESS cycle
    i_req1 = 1; i_addr1 = 16'h0055;
    step();
    check("l1_rd_c1", {16'd0, m_addr1}, 32'h55);
    check("l1_rd_c1_ctl", {30'd0, busy1, i_ack1}, 32'h2);
    step();
    check("l1_rd_ack", {31'd0, i_ack1}, 32'h1);
    check("l1_rd_data", i_rdata1, 32'hC0DE0055);
    i_req1 = 0;
    step();
    check("l1_rd_idle", {31'd0, busy1}, 32'h0);
    d_req1 = 1; d_we1 = 1; d_addr1 = 16'h0066; d_wdata1 = 32'hCAFEF00D;
    step();
    check("l1_wr_c1_we", {31'd0, m_we1}, 32'h1);
    check("l1_wr_c1_wdata", m_wdata1, 32'hCAFEF00D);
    step();
    check("l1_wr_ack", {30'd0, m_we1, d_ack1}, 32'h1);
    check("l1_wr_d_rdata", d_rdata1, 32'h0);
    d_req1 = 0; d_we1 = 0;
    step();
    check("l1_we_count", we1_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
